// File: rtl/reg_write_checker.sv
// reg_write_checker
// Self-check unit for the 8-bit computer. It taps the register-file load
// enables and write-back data, and compares each write-back event, in order,
// against a programmed list of expected (register, value) pairs.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/addr/reg/value write one expectation entry (ignored while running)
//   exp_count             number of entries to check, sampled on start
//   start, clear          arm a run / return from DONE to IDLE
//   wr_en, wr_data        per-register load enables and write-back data
//   busy, done, pass      run status; pass is valid while done
//   timeout, multi_wr     sticky error flags for the current run
//   fail_count            saturating mismatch count
//   entry_idx             entries consumed so far
//   first_fail_idx/_data  entry index and observed data of the first mismatch
module reg_write_checker #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 2,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 8,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int RW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [RW-1:0]              cfg_reg,
  input  logic [DATA_W-1:0]          cfg_value,
  input  logic [AW:0]                exp_count,
  input  logic                       start,
  input  logic                       clear,
  input  logic [NUM_REGS-1:0]        wr_en,
  input  logic [NUM_REGS*DATA_W-1:0] wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic                       multi_wr,
  output logic [CNT_W-1:0]           fail_count,
  output logic [AW:0]                entry_idx,
  output logic [AW-1:0]              first_fail_idx,
  output logic [DATA_W-1:0]          first_fail_data
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [RW-1:0]     rsel;
    logic [DATA_W-1:0] value;
  } entry_t;

  state_e            state_q, state_d;
  logic [AW:0]       n_q, n_d;
  logic [AW:0]       entry_q, entry_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [AW-1:0]     ff_idx_q, ff_idx_d;
  logic [DATA_W-1:0] ff_data_q, ff_data_d;
  logic              timeout_q, timeout_d;
  logic              multi_q, multi_d;
  logic [TW-1:0]     idle_q, idle_d;

  // Expectation memory: not reset, so a run can be repeated after rst_n.
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (cfg_we && state_q != RUN && {1'b0, cfg_addr} < DEPTH_N)
      mem_q[cfg_addr] <= '{rsel: cfg_reg, value: cfg_value};
  end

  // Observed register is the lowest set enable; scan high-to-low so the
  // lowest index is the last assignment.
  logic [RW-1:0]     obs_reg;
  logic [DATA_W-1:0] obs_data;
  always_comb begin
    obs_reg  = '0;
    obs_data = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (wr_en[i]) begin
        obs_reg  = RW'(i);
        obs_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  logic        event_w, multi_w, mismatch_w;
  logic [AW:0] n_start;
  entry_t      exp_e;

  assign event_w    = |wr_en;
  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_w    = |(wr_en & (wr_en - NUM_REGS'(1)));
  assign exp_e      = mem_q[entry_q[AW-1:0]];
  assign mismatch_w = multi_w || obs_reg != exp_e.rsel || obs_data != exp_e.value;
  assign n_start    = (exp_count > DEPTH_N) ? DEPTH_N : exp_count;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    entry_d   = entry_q;
    fail_d    = fail_q;
    ff_idx_d  = ff_idx_q;
    ff_data_d = ff_data_q;
    timeout_d = timeout_q;
    multi_d   = multi_q;
    idle_d    = idle_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && clear) begin
          state_d   = IDLE;
          entry_d   = '0;
          fail_d    = '0;
          ff_idx_d  = '0;
          ff_data_d = '0;
          timeout_d = 1'b0;
          multi_d   = 1'b0;
          idle_d    = '0;
        end else if (start) begin
          state_d   = (n_start == '0) ? DONE : RUN;
          n_d       = n_start;
          entry_d   = '0;
          fail_d    = '0;
          ff_idx_d  = '0;
          ff_data_d = '0;
          timeout_d = 1'b0;
          multi_d   = 1'b0;
          idle_d    = '0;
        end
      end
      RUN: begin
        if (event_w) begin
          idle_d  = '0;
          entry_d = entry_q + 1'b1;
          if (multi_w) multi_d = 1'b1;
          if (mismatch_w) begin
            // The counter cannot wrap back to zero, so zero means "first".
            if (fail_q == '0) begin
              ff_idx_d  = entry_q[AW-1:0];
              ff_data_d = obs_data;
            end
            if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + 1'b1;
          end
          if (entry_q + 1'b1 == n_q) state_d = DONE;
        end else if (TIMEOUT != 0) begin
          // idle_q holds the number of silent cycles already seen.
          if (idle_q == TW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      entry_q   <= '0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_data_q <= '0;
      timeout_q <= 1'b0;
      multi_q   <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      entry_q   <= entry_d;
      fail_q    <= fail_d;
      ff_idx_q  <= ff_idx_d;
      ff_data_q <= ff_data_d;
      timeout_q <= timeout_d;
      multi_q   <= multi_d;
      idle_q    <= idle_d;
    end
  end

  // Outputs are decoded from flops only; no input reaches them combinationally.
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = done && fail_q == '0 && !timeout_q && !multi_q;
  assign timeout         = timeout_q;
  assign multi_wr        = multi_q;
  assign fail_count      = fail_q;
  assign entry_idx       = entry_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_data = ff_data_q;

endmodule

// File: tb/tb_reg_write_checker.sv
module tb_reg_write_checker;
  localparam int DATA_W = 8, NUM_REGS = 2, DEPTH = 16, TIMEOUT = 8, CNT_W = 2;
  localparam int AW = 4, RW = 1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       cfg_we = 1'b0;
  logic [AW-1:0]              cfg_addr = '0;
  logic [RW-1:0]              cfg_reg = '0;
  logic [DATA_W-1:0]          cfg_value = '0;
  logic [AW:0]                exp_count = '0;
  logic                       start = 1'b0, clear = 1'b0;
  logic [NUM_REGS-1:0]        wr_en = '0;
  logic [NUM_REGS*DATA_W-1:0] wr_data = '0;
  logic                       busy, done, pass, timeout, multi_wr;
  logic [CNT_W-1:0]           fail_count;
  logic [AW:0]                entry_idx;
  logic [AW-1:0]              first_fail_idx;
  logic [DATA_W-1:0]          first_fail_data;

  reg_write_checker #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_reg(cfg_reg), .cfg_value(cfg_value), .exp_count(exp_count),
    .start(start), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .multi_wr(multi_wr), .fail_count(fail_count), .entry_idx(entry_idx),
    .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data));

  always #5 clk = ~clk;

  typedef struct {
    bit pass; int fc; int idx; bit to; bit mw; bit chkff; int ffidx; int ffdata;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   vectors = 0, miscompares = 0;
  logic done_d1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: a rising done is the DUT presenting a run result.
  always @(negedge clk) begin
    if (done && !done_d1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = q.pop_front();
        chk("pass", 32'(pass), 32'(me.pass));
        chk("fail_count", 32'(fail_count), me.fc);
        chk("entry_idx", 32'(entry_idx), me.idx);
        chk("timeout", 32'(timeout), 32'(me.to));
        chk("multi_wr", 32'(multi_wr), 32'(me.mw));
        if (me.chkff) begin
          chk("first_fail_idx", 32'(first_fail_idx), me.ffidx);
          chk("first_fail_data", 32'(first_fail_data), me.ffdata);
        end
      end
    end
    done_d1 = done;
  end

  task automatic push(input bit p, input int fc, input int idx, input bit to,
                      input bit mw, input bit chkff, input int ffi, input int ffd);
    exp_t e;
    e = '{p, fc, idx, to, mw, chkff, ffi, ffd};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic program_entry(input int a, input int r, input int v);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_reg = RW'(r); cfg_value = DATA_W'(v);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    exp_count = (AW+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int r, input int v, input int gap);
    wr_en = '0; wr_en[r] = 1'b1;
    wr_data = '0; wr_data[r*DATA_W +: DATA_W] = DATA_W'(v);
    tick();
    wr_en = '0;
    repeat (gap) tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    if (!done) chk("wait_done_budget", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_status", 32'({timeout, multi_wr, fail_count, entry_idx, first_fail_idx, first_fail_data}), 0);
    rst_n = 1'b1;
    tick();

    // MOV sequence
    program_entry(0, 0, 42);
    program_entry(1, 1, 123);
    push(1, 0, 2, 0, 0, 0, 0, 0);
    start_run(2);
    chk("mov_busy", 32'(busy), 1);
    wr(0, 42, 0);
    chk("mov_idx_mid", 32'(entry_idx), 1);
    wr(1, 123, 0);
    chk("mov_done_same_edge", 32'(done), 1);
    wait_done();

    // ADD/SHL sequence, re-armed straight from DONE
    program_entry(0, 0, 2);
    program_entry(1, 1, 3);
    program_entry(2, 0, 5);
    program_entry(3, 0, 5);
    program_entry(4, 0, 10);
    push(1, 0, 5, 0, 0, 0, 0, 0);
    start_run(5);
    wr(0, 2, 1); wr(1, 3, 2); wr(0, 5, 3); wr(0, 5, 1); wr(0, 10, 0);
    wait_done();
    push(0, 1, 5, 0, 0, 1, 2, 6);
    start_run(5);
    wr(0, 2, 2); wr(1, 3, 1); wr(0, 6, 3); wr(0, 5, 1); wr(0, 10, 0);
    wait_done();

    // Wrong register
    program_entry(0, 0, 42);
    push(0, 1, 1, 0, 0, 1, 0, 42);
    start_run(1);
    wr(1, 42, 0);
    wait_done();

    // Multi-write then saturation (CNT_W=2)
    for (int i = 0; i < 6; i++) program_entry(i, 0, 16 + i);
    push(0, 3, 6, 0, 1, 1, 0, 16);
    start_run(6);
    wr_en = 2'b11; wr_data = {8'h77, 8'h10};
    tick();
    wr_en = '0;
    chk("multi_flag", 32'(multi_wr), 1);
    chk("multi_idx", 32'(entry_idx), 1);
    chk("multi_fc", 32'(fail_count), 1);
    for (int i = 0; i < 5; i++) wr(0, 0, 0);
    wait_done();

    // Timeout: done exactly TIMEOUT cycles after the last event
    program_entry(0, 0, 7);
    program_entry(1, 0, 8);
    program_entry(2, 0, 9);
    push(0, 0, 1, 1, 0, 0, 0, 0);
    start_run(3);
    wr(0, 7, 0);
    cnt = 0;
    while (!done && cnt < 50) begin tick(); cnt++; end
    chk("timeout_latency", cnt, TIMEOUT);
    chk("timeout_pass", 32'(pass), 0);

    // clear, then exp_count=0
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_done", 32'(done), 0);
    chk("clear_timeout", 32'(timeout), 0);
    push(1, 0, 0, 0, 0, 0, 0, 0);
    start_run(0);
    chk("n0_done", 32'(done), 1);
    chk("n0_pass", 32'(pass), 1);

    // exp_count=20 clamps to DEPTH=16; late events are ignored
    for (int i = 0; i < 16; i++) program_entry(i, i % 2, 100 + i);
    push(1, 0, 16, 0, 0, 0, 0, 0);
    start_run(20);
    for (int i = 0; i < 15; i++) wr(i % 2, 100 + i, 0);
    chk("clamp_not_done", 32'(done), 0);
    chk("clamp_idx15", 32'(entry_idx), 15);
    wr(1, 115, 0);
    wait_done();
    wr(0, 1, 0);
    chk("clamp_idx_hold", 32'(entry_idx), 16);

    // Reset mid-RUN, then rerun without reprogramming
    start_run(16);
    wr(0, 100, 0); wr(1, 101, 0); wr(1, 55, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_status", 32'({done, pass, fail_count, entry_idx, first_fail_idx, first_fail_data}), 0);
    #1 rst_n = 1'b1;
    tick();
    push(1, 0, 16, 0, 0, 0, 0, 0);
    start_run(16);
    for (int i = 0; i < 16; i++) wr(i % 2, 100 + i, i % 3);
    wait_done();

    // clear and start together in DONE: clear wins
    exp_count = 5'd2; clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("clr_start_done", 32'(done), 0);
    chk("clr_start_busy", 32'(busy), 0);

    repeat (3) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
